// File: rtl/facto_driver.sv
`default_nettype none
// ============================================================================
// facto_driver : bus-master sequencer that runs one factorial-core operation
//                per request and returns the 128-bit result.
// Build option : FACTO_DRIVER_POLL_EN -> poll OPDONE instead of using interrupt
// Revision     : 1.0
// ============================================================================
module facto_driver #(
   parameter logic [15:0] ADDR_OPSTART = 16'h0000,
   parameter logic [15:0] ADDR_OPCLEAR = 16'h0008,
   parameter logic [15:0] ADDR_INTREN  = 16'h0010,
   parameter logic [15:0] ADDR_OPERAND = 16'h0018,
   parameter logic [15:0] ADDR_OPDONE  = 16'h0020,
   parameter logic [15:0] ADDR_RH      = 16'h0028,
   parameter logic [15:0] ADDR_RL      = 16'h0030,
   parameter int unsigned TIMEOUT      = 1024
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        op_valid,
   output logic        op_ready,
   input  logic [63:0] op_operand,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [63:0] res_hi,
   output logic [63:0] res_lo,
   output logic        res_err,
   output logic        m_sel,
   output logic        m_wr,
   output logic [15:0] m_addr,
   output logic [63:0] m_dout,
   input  logic [63:0] m_din,
   input  logic        interrupt
);

   typedef enum logic [3:0] {
      S_IDLE    = 4'd0,
      S_W_CLR1  = 4'd1,
      S_W_CLR0  = 4'd2,
      S_W_OPR   = 4'd3,
      S_W_IEN   = 4'd4,
      S_W_START = 4'd5,
      S_WAIT    = 4'd6,
      S_R_RH    = 4'd7,
      S_R_RL    = 4'd8,
      S_W_STOP  = 4'd9,
      S_RESP    = 4'd10
   } state_t;

`ifdef FACTO_DRIVER_POLL_EN
   localparam logic [63:0] c_IEN_VAL = 64'd0;
`else
   localparam logic [63:0] c_IEN_VAL = 64'd1;
`endif

   state_t      state_q, state_d;
   logic [63:0] operand_q, operand_d;
   logic [31:0] wait_cnt_q, wait_cnt_d;
   logic [63:0] res_hi_q, res_hi_d;
   logic [63:0] res_lo_q, res_lo_d;
   logic        res_err_q, res_err_d;

   logic [31:0] w_cnt_inc;
   logic        w_tmo;
   logic        w_done;
   logic        w_poll_slot;

   assign w_cnt_inc = wait_cnt_q + 32'd1;
   assign w_tmo     = (TIMEOUT != 0) && (w_cnt_inc == TIMEOUT);

`ifdef FACTO_DRIVER_POLL_EN
   // OPDONE is read on WAIT cycles 1, 5, 9, ... and its data closes that cycle.
   logic w_unused_irq;
   assign w_unused_irq = interrupt;
   assign w_poll_slot  = (wait_cnt_q[1:0] == 2'b00);
   assign w_done       = w_poll_slot & m_din[0];
`else
   assign w_poll_slot  = 1'b0;
   assign w_done       = interrupt;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         operand_q  <= '0;
         wait_cnt_q <= '0;
         res_hi_q   <= '0;
         res_lo_q   <= '0;
         res_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         operand_q  <= operand_d;
         wait_cnt_q <= wait_cnt_d;
         res_hi_q   <= res_hi_d;
         res_lo_q   <= res_lo_d;
         res_err_q  <= res_err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      operand_d  = operand_q;
      wait_cnt_d = wait_cnt_q;
      res_hi_d   = res_hi_q;
      res_lo_d   = res_lo_q;
      res_err_d  = res_err_q;
      m_sel      = 1'b0;
      m_wr       = 1'b0;
      m_addr     = '0;
      m_dout     = '0;
      case (state_q)
         S_IDLE: begin
            if (op_valid) begin
               operand_d = op_operand;
               res_err_d = 1'b0;
               state_d   = S_W_CLR1;
            end
         end
         S_W_CLR1: begin
            m_sel   = 1'b1;
            m_wr    = 1'b1;
            m_addr  = ADDR_OPCLEAR;
            m_dout  = 64'd1;
            state_d = S_W_CLR0;
         end
         S_W_CLR0: begin
            m_sel   = 1'b1;
            m_wr    = 1'b1;
            m_addr  = ADDR_OPCLEAR;
            state_d = S_W_OPR;
         end
         S_W_OPR: begin
            m_sel   = 1'b1;
            m_wr    = 1'b1;
            m_addr  = ADDR_OPERAND;
            m_dout  = operand_q;
            state_d = S_W_IEN;
         end
         S_W_IEN: begin
            m_sel   = 1'b1;
            m_wr    = 1'b1;
            m_addr  = ADDR_INTREN;
            m_dout  = c_IEN_VAL;
            state_d = S_W_START;
         end
         S_W_START: begin
            m_sel      = 1'b1;
            m_wr       = 1'b1;
            m_addr     = ADDR_OPSTART;
            m_dout     = 64'd1;
            wait_cnt_d = '0;
            state_d    = S_WAIT;
         end
         S_WAIT: begin
            wait_cnt_d = w_cnt_inc;
            if (w_poll_slot) begin
               m_sel  = 1'b1;
               m_addr = ADDR_OPDONE;
            end
            // Completion takes priority over a timeout landing in the same cycle.
            if (w_done) begin
               state_d = S_R_RH;
            end else if (w_tmo) begin
               res_err_d = 1'b1;
               res_hi_d  = '0;
               res_lo_d  = '0;
               state_d   = S_W_STOP;
            end
         end
         S_R_RH: begin
            m_sel    = 1'b1;
            m_addr   = ADDR_RH;
            res_hi_d = m_din;
            state_d  = S_R_RL;
         end
         S_R_RL: begin
            m_sel    = 1'b1;
            m_addr   = ADDR_RL;
            res_lo_d = m_din;
            state_d  = S_W_STOP;
         end
         S_W_STOP: begin
            m_sel   = 1'b1;
            m_wr    = 1'b1;
            m_addr  = ADDR_OPSTART;
            state_d = S_RESP;
         end
         S_RESP: begin
            if (res_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign op_ready  = (state_q == S_IDLE);
   assign res_valid = (state_q == S_RESP);
   assign res_hi    = res_hi_q;
   assign res_lo    = res_lo_q;
   assign res_err   = res_err_q;

endmodule
`default_nettype wire

// File: tb/tb_facto_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_facto_driver : drives facto_driver against a behavioural factorial core
//                   and checks results, bus traffic and latency.
// Revision        : 1.0
// ============================================================================
module tb_facto_driver;

   localparam int unsigned C_TMO      = 16;
   localparam logic [15:0] C_OPSTART  = 16'h0000;
   localparam logic [15:0] C_OPCLEAR  = 16'h0008;
   localparam logic [15:0] C_INTREN   = 16'h0010;
   localparam logic [15:0] C_OPERAND  = 16'h0018;
   localparam logic [15:0] C_OPDONE   = 16'h0020;
   localparam logic [15:0] C_RH       = 16'h0028;
   localparam logic [15:0] C_RL       = 16'h0030;
`ifdef FACTO_DRIVER_POLL_EN
   localparam bit C_POLL = 1'b1;
`else
   localparam bit C_POLL = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        op_valid = 1'b0;
   logic        res_ready = 1'b0;
   logic [63:0] op_operand = '0;
   logic        op_ready, res_valid, res_err, m_sel, m_wr, interrupt;
   logic [63:0] res_hi, res_lo, m_dout, m_din;
   logic [15:0] m_addr;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   facto_driver #(.TIMEOUT(C_TMO)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .op_valid   (op_valid),
      .op_ready   (op_ready),
      .op_operand (op_operand),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_hi     (res_hi),
      .res_lo     (res_lo),
      .res_err    (res_err),
      .m_sel      (m_sel),
      .m_wr       (m_wr),
      .m_addr     (m_addr),
      .m_dout     (m_dout),
      .m_din      (m_din),
      .interrupt  (interrupt)
   );

   function automatic logic [127:0] fact(input logic [63:0] n);
      logic [127:0] r;
      r = 128'd1;
      for (int i = 2; i <= 40 && 64'(i) <= n; i++) r = r * 128'(i);
      return r;
   endfunction

   // ---------------- behavioural factorial core ----------------
   int unsigned  cyc = 0;
   logic [63:0]  core_opr = '0;
   logic         core_ien = 1'b0;
   logic         core_done = 1'b0;
   logic         core_busy = 1'b0;
   logic [127:0] core_res = '0;
   int           core_dly = 0;      // edges from OPSTART to done; negative = never
   int unsigned  core_tgt = 0;
   logic         irq_force = 1'b0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (core_busy && cyc == core_tgt) begin
         core_done <= 1'b1;
         core_busy <= 1'b0;
      end
      if (m_sel && m_wr) begin
         case (m_addr)
            C_OPCLEAR: if (m_dout[0]) begin
               core_done <= 1'b0;
               core_busy <= 1'b0;
               core_res  <= '0;
            end
            C_INTREN:  core_ien <= m_dout[0];
            C_OPERAND: core_opr <= m_dout;
            C_OPSTART: if (m_dout[0]) begin
               core_res <= fact(core_opr);
               if (core_dly == 0) core_done <= 1'b1;
               else if (core_dly > 0) begin
                  core_busy <= 1'b1;
                  core_tgt  <= cyc + 32'(core_dly);
               end
            end
            default: ;
         endcase
      end
   end

   assign interrupt = (core_done & core_ien) | irq_force;
   assign m_din = (m_addr == C_RH)     ? core_res[127:64] :
                  (m_addr == C_RL)     ? core_res[63:0]   :
                  (m_addr == C_OPDONE) ? {63'd0, core_done} : 64'd0;

`ifdef FACTO_DRIVER_POLL_EN
   // In polling builds the interrupt pin carries noise that must be ignored.
   always @(negedge clk) irq_force <= 1'($urandom);
`endif

   // ---------------- bus monitor ----------------
   typedef struct packed {
      logic [31:0] off;
      logic        wr;
      logic [15:0] addr;
      logic [63:0] data;
   } txn_t;

   function automatic txn_t mk(input int unsigned off, input logic wr,
                               input logic [15:0] addr, input logic [63:0] data);
      txn_t t;
      t.off = off; t.wr = wr; t.addr = addr; t.data = data;
      return t;
   endfunction

   txn_t        obs_q[$];
   txn_t        exp_q[$];
   int unsigned hs_cyc = 0;
   int unsigned idle_bus_err = 0;

   always @(posedge clk) begin
      if (op_valid && op_ready) hs_cyc <= cyc;
      if (m_sel) obs_q.push_back(mk(cyc - hs_cyc, m_wr, m_addr, m_wr ? m_dout : 64'd0));
      else if (m_wr || m_addr != '0 || m_dout != '0) idle_bus_err <= idle_bus_err + 1;
   end

   // ---------------- reference model ----------------
   logic [127:0] exp_res;
   logic         exp_err;
   int unsigned  exp_rv;

   // Offsets are in cycles after the handshake edge; WAIT cycle k is offset 5+k.
   task automatic ref_model(input logic [63:0] opnd, input int dly);
      int unsigned w;
      bit hit, vis, look;
      w = 0; hit = 1'b0;
      exp_q.delete();
      exp_q.push_back(mk(1, 1'b1, C_OPCLEAR, 64'd1));
      exp_q.push_back(mk(2, 1'b1, C_OPCLEAR, 64'd0));
      exp_q.push_back(mk(3, 1'b1, C_OPERAND, opnd));
      exp_q.push_back(mk(4, 1'b1, C_INTREN, C_POLL ? 64'd0 : 64'd1));
      exp_q.push_back(mk(5, 1'b1, C_OPSTART, 64'd1));
      for (int k = 1; k <= int'(C_TMO) && !hit; k++) begin
         vis  = (dly >= 0) && (k >= dly + 1);
         look = C_POLL ? ((k - 1) % 4 == 0) : 1'b1;
         if (C_POLL && look) exp_q.push_back(mk(5 + k, 1'b0, C_OPDONE, 64'd0));
         if (vis && look) hit = 1'b1;
         w = k;
      end
      if (hit) begin
         exp_q.push_back(mk(6 + w, 1'b0, C_RH, 64'd0));
         exp_q.push_back(mk(7 + w, 1'b0, C_RL, 64'd0));
         exp_q.push_back(mk(8 + w, 1'b1, C_OPSTART, 64'd0));
         exp_res = fact(opnd);
         exp_err = 1'b0;
         exp_rv  = 9 + w;
      end else begin
         exp_q.push_back(mk(6 + w, 1'b1, C_OPSTART, 64'd0));
         exp_res = '0;
         exp_err = 1'b1;
         exp_rv  = 7 + w;
      end
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic run_op(input logic [63:0] opnd, input int dly, input int hold);
      int guard;
      core_dly = dly;
      ref_model(opnd, dly);
      @(negedge clk);
      obs_q.delete();
      op_valid   = 1'b1;
      op_operand = opnd;
      guard = 0;
      while (!op_ready && guard < 50) begin @(negedge clk); guard++; end
      @(negedge clk);
      op_valid   = 1'b0;
      op_operand = '0;
      chk("err_clear_on_accept", res_err, 0);
      guard = 0;
      while (!res_valid && guard < 300) begin @(negedge clk); guard++; end
      chk("res_valid_reached", res_valid, 1);
      chk("resp_latency", cyc - hs_cyc, exp_rv);
      chk("res_hi", res_hi, exp_res[127:64]);
      chk("res_lo", res_lo, exp_res[63:0]);
      chk("res_err", res_err, exp_err);
      chk("bus_count", obs_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
         chk($sformatf("bus_txn%0d", i), (i < obs_q.size()) ? obs_q[i] : '0, exp_q[i]);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("hold_valid", res_valid, 1);
         chk("hold_result", {res_hi, res_lo}, exp_res);
      end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      chk("back_to_idle_ready", op_ready, 1);
      chk("back_to_idle_valid", res_valid, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired observed=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_op_ready", op_ready, 1);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_err", res_err, 0);
      chk("rst_bus", {m_sel, m_wr, m_addr, m_dout}, 0);
      chk("rst_result", {res_hi, res_lo}, 0);
      reset_n = 1'b1;

      run_op(64'd5, 3, 2);
      chk("fact5_lo", res_lo, 64'd120);
      run_op(64'd0, 1, 1);
      chk("fact0_lo", res_lo, 64'd1);
      run_op(64'd1, 0, 1);
      chk("fact1_lo", res_lo, 64'd1);
      run_op(64'd21, 6, 10);
      chk("fact21_hi", res_hi, 64'h2);
      chk("fact21_lo", res_lo, 64'hC5077D36B8C40000);

      // core never finishes -> timeout after TIMEOUT WAIT cycles
      run_op(64'd7, -1, 3);
      chk("tmo_err", res_err, 1);
      // done visible in the last WAIT cycle (interrupt build completes, poll build times out)
      run_op(64'd6, 15, 1);
      run_op(64'd8, 14, 1);

      repeat (8) run_op(64'($urandom_range(0, 34)), int'($urandom_range(0, 12)),
                        int'($urandom_range(1, 4)));

      run_op(64'd21, 2, 1);
      // abandon an operation mid-WAIT with an asynchronous reset
      core_dly = -1;
      @(negedge clk);
      op_valid = 1'b1; op_operand = 64'd9;
      @(negedge clk);
      op_valid = 1'b0; op_operand = '0;
      repeat (8) @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("midrst_op_ready", op_ready, 1);
      chk("midrst_res_valid", res_valid, 0);
      chk("midrst_bus", {m_sel, m_wr, m_addr, m_dout}, 0);
      chk("midrst_result", {res_hi, res_lo}, 0);
      chk("midrst_err", res_err, 0);
      obs_q.delete();
      repeat (3) @(negedge clk);
      chk("midrst_no_bus", obs_q.size(), 0);
      reset_n = 1'b1;
      run_op(64'd3, 2, 1);
      chk("fact3_lo", res_lo, 64'd6);

      chk("idle_bus_quiet", idle_bus_err, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
